mpu_sequencer: RTL and testbench

Run-control sequencer for the MPU execution stage. It decides on each cycle whether the current instruction retires, which means advancing the instruction pointer and committing its register write. It turns the execution stage's one-cycle `hm_start` and `user_irq` strobes into multi-cycle host-memory and CPU-interrupt handshakes, stalling the pipeline until each completes. It sits between the CSR block (run enable, error status), the execution stage and the host memory port.

---
 rtl/mpu_sequencer.sv | 123 ++++++++++++
 tb/tb_mpu_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_sequencer.sv
// Run-control sequencer for the MPU execution stage: decides retirement and
// turns hm_start/user_irq into stalling host-memory and CPU-interrupt handshakes.
module mpu_sequencer #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        en,
    output logic        ip_en,
    input  logic        hm_start,
    input  logic [63:0] hm_addr,
    output logic        hm_req,
    output logic [63:0] hm_req_addr,
    input  logic        hm_ack,
    input  logic [63:0] hm_rdata,
    output logic [63:0] hm_data,
    input  logic        user_irq,
    input  logic [63:0] user_data,
    output logic        irq,
    output logic [63:0] irq_data,
    input  logic        irq_ack,
    input  logic        we_in,
    output logic        we,
    output logic        err,
    output logic        busy
);

    localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RUN      = 3'd1;
    localparam logic [2:0] S_MEM_WAIT = 3'd2;
    localparam logic [2:0] S_MEM_DONE = 3'd3;
    localparam logic [2:0] S_IRQ_WAIT = 3'd4;
    localparam logic [2:0] S_ERROR    = 3'd5;

    logic [2:0]    state;
    logic [CW-1:0] cnt;

    always_comb begin
        ip_en = 1'b0;
        we    = 1'b0;
        case (state)
            S_RUN: begin
                if (en && !hm_start && !user_irq) begin
                    ip_en = 1'b1;
                    we    = we_in;
                end
            end
            S_MEM_DONE: begin
                ip_en = 1'b1;
                we    = we_in;
            end
            // The INT retires in the ack cycle but never writes a register.
            S_IRQ_WAIT: ip_en = irq_ack;
            default: ;
        endcase
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            hm_req      <= 1'b0;
            hm_req_addr <= '0;
            hm_data     <= '0;
            irq         <= 1'b0;
            irq_data    <= '0;
            err         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en) state <= S_RUN;
                end
                S_RUN: begin
                    if (!en) begin
                        state <= S_IDLE;
                    end else if (hm_start) begin
                        hm_req_addr <= hm_addr;
                        hm_req      <= 1'b1;
                        cnt         <= '0;
                        state       <= S_MEM_WAIT;
                    end else if (user_irq) begin
                        irq_data <= user_data;
                        irq      <= 1'b1;
                        state    <= S_IRQ_WAIT;
                    end
                end
                S_MEM_WAIT: begin
                    if (cnt != '1) cnt <= cnt + 1'b1;
                    // An ack in the last allowed cycle beats the timeout.
                    if (hm_ack) begin
                        hm_data <= hm_rdata;
                        hm_req  <= 1'b0;
                        state   <= S_MEM_DONE;
                    end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                        hm_req <= 1'b0;
                        err    <= 1'b1;
                        state  <= S_ERROR;
                    end
                end
                S_MEM_DONE: state <= S_RUN;
                S_IRQ_WAIT: begin
                    if (irq_ack) begin
                        irq   <= 1'b0;
                        state <= S_RUN;
                    end
                end
                S_ERROR: begin
                    if (!en) begin
                        err   <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mpu_sequencer.sv
// Bench for mpu_sequencer: cycle vector table, directed MLOAD/INT/timeout/reset
// sequences and randomized transactions scored against transaction-level rules.
module tb_mpu_sequencer;

    localparam int TB_TIMEOUT = 8;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        en = 1'b0;
    logic        ip_en;
    logic        hm_start = 1'b0;
    logic [63:0] hm_addr = '0;
    logic        hm_req;
    logic [63:0] hm_req_addr;
    logic        hm_ack = 1'b0;
    logic [63:0] hm_rdata = '0;
    logic [63:0] hm_data;
    logic        user_irq = 1'b0;
    logic [63:0] user_data = '0;
    logic        irq;
    logic [63:0] irq_data;
    logic        irq_ack = 1'b0;
    logic        we_in = 1'b0;
    logic        we;
    logic        err;
    logic        busy;

    mpu_sequencer #(.TIMEOUT(TB_TIMEOUT)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .en         (en),
        .ip_en      (ip_en),
        .hm_start   (hm_start),
        .hm_addr    (hm_addr),
        .hm_req     (hm_req),
        .hm_req_addr(hm_req_addr),
        .hm_ack     (hm_ack),
        .hm_rdata   (hm_rdata),
        .hm_data    (hm_data),
        .user_irq   (user_irq),
        .user_data  (user_data),
        .irq        (irq),
        .irq_data   (irq_data),
        .irq_ack    (irq_ack),
        .we_in      (we_in),
        .we         (we),
        .err        (err),
        .busy       (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] model_hm_data = '0;

    // Field order: en hs ui wi hack iack _ ip we busy req irq err
    typedef struct packed {
        logic en, hs, ui, wi, hack, iack;
        logic ip, we, busy, req, irq, err;
    } vec_t;
    vec_t vt[18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_plain(input logic wi);
        hm_start = 1'b0;
        user_irq = 1'b0;
        we_in    = wi;
        @(negedge sys_clk);
        check("plain_ip_en", ip_en, 1);
        check("plain_we", we, wi);
        tick();
    endtask

    // MLOAD acked in wait cycle k; k > TB_TIMEOUT means no ack at all.
    task automatic do_mload(input logic [63:0] addr, input logic [63:0] data, input int k,
                            input logic wi, input logic both, input logic drop);
        int reqcnt = 0, ipc = 0, wec = 0, cyc = 0;
        logic irq_seen = 1'b0, done = 1'b0;
        hm_start = 1'b1;
        hm_addr  = addr;
        user_irq = both;
        user_data = {$urandom, $urandom};
        we_in    = wi;
        hm_rdata = data;
        while (!done && cyc < 64) begin
            if (hm_req) reqcnt++;
            hm_ack = hm_req && (reqcnt == k);
            if (drop && reqcnt == 1) en = 1'b0;
            @(negedge sys_clk);
            if (ip_en) ipc++;
            if (we) wec++;
            if (irq) irq_seen = 1'b1;
            if (ip_en || err) done = 1'b1;
            tick();
            cyc++;
        end
        hm_ack = 1'b0;
        hm_start = 1'b0;
        user_irq = 1'b0;
        check("mload_finished", done, 1);
        check("mload_irq_held_off", irq_seen, 0);
        check("mload_req_addr", hm_req_addr, addr);
        check("mload_no_second_req", hm_req, 0);
        if (k <= TB_TIMEOUT) begin
            model_hm_data = data;
            check("mload_req_cycles", reqcnt, k);
            check("mload_retire_count", ipc, 1);
            check("mload_we_count", wec, wi);
            check("mload_latency", cyc, k + 2);
            check("mload_data", hm_data, model_hm_data);
            check("mload_err", err, 0);
            if (drop) begin
                @(negedge sys_clk);
                check("drop_en_no_retire", ip_en, 0);
                tick();
                check("drop_en_idle", busy, 0);
                en = 1'b1;
                tick();
            end
        end else begin
            check("timeout_req_cycles", reqcnt, TB_TIMEOUT);
            check("timeout_no_retire", ipc, 0);
            check("timeout_latency", cyc, TB_TIMEOUT + 2);
            check("timeout_err", err, 1);
            hm_ack = 1'b1;
            hm_rdata = ~data;
            @(negedge sys_clk);
            check("error_ip_en", ip_en, 0);
            tick();
            hm_ack = 1'b0;
            check("late_ack_data", hm_data, model_hm_data);
            check("late_ack_err_held", err, 1);
            check("late_ack_req", hm_req, 0);
            en = 1'b0;
            @(negedge sys_clk);
            check("error_busy", busy, 1);
            tick();
            check("error_clear_err", err, 0);
            check("error_to_idle", busy, 0);
            en = 1'b1;
            tick();
        end
    endtask

    // INT acked after irq has been high for k cycles.
    task automatic do_int(input logic [63:0] payload, input int k, input logic wi);
        int irqcnt = 0, ipc = 0, wec = 0, cyc = 0;
        logic req_seen = 1'b0, done = 1'b0;
        hm_start  = 1'b0;
        user_irq  = 1'b1;
        user_data = payload;
        we_in     = wi;
        while (!done && cyc < 64) begin
            if (irq) irqcnt++;
            irq_ack = irq && (irqcnt == k);
            @(negedge sys_clk);
            if (ip_en) ipc++;
            if (we) wec++;
            if (hm_req) req_seen = 1'b1;
            if (ip_en) done = 1'b1;
            tick();
            cyc++;
        end
        irq_ack = 1'b0;
        user_irq = 1'b0;
        check("int_finished", done, 1);
        check("int_irq_cycles", irqcnt, k);
        check("int_retire_count", ipc, 1);
        check("int_no_we", wec, 0);
        check("int_latency", cyc, k + 1);
        check("int_payload", irq_data, payload);
        check("int_irq_cleared", irq, 0);
        check("int_no_hm_req", req_seen, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = 12'b000000_000000;
        vt[1]  = 12'b100100_000000;
        vt[2]  = 12'b100100_111000;
        vt[3]  = 12'b100000_101000;
        vt[4]  = 12'b100100_111000;
        vt[5]  = 12'b100100_111000;
        vt[6]  = 12'b000100_001000;
        vt[7]  = 12'b100100_000000;
        vt[8]  = 12'b111100_001000;
        vt[9]  = 12'b111110_001100;
        vt[10] = 12'b111100_111000;
        vt[11] = 12'b101100_001000;
        vt[12] = 12'b101100_001010;
        vt[13] = 12'b101101_101010;
        vt[14] = 12'b100111_111000;
        vt[15] = 12'b100000_101000;
        vt[16] = 12'b000000_001000;
        vt[17] = 12'b000010_000000;

        tick();
        tick();
        sys_rst = 1'b0;
        #1;
        check("rst_hm_req", hm_req, 0);
        check("rst_irq", irq, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_hm_req_addr", hm_req_addr, 0);
        check("rst_hm_data", hm_data, 0);
        check("rst_irq_data", irq_data, 0);

        hm_addr   = 64'h40;
        hm_rdata  = 64'hA5A5_0000_1234_5678;
        user_data = 64'h77;
        for (int i = 0; i < 18; i++) begin
            en = vt[i].en; hm_start = vt[i].hs; user_irq = vt[i].ui;
            we_in = vt[i].wi; hm_ack = vt[i].hack; irq_ack = vt[i].iack;
            @(negedge sys_clk);
            check($sformatf("vec%0d_ip_en", i), ip_en, vt[i].ip);
            check($sformatf("vec%0d_we", i), we, vt[i].we);
            check($sformatf("vec%0d_busy", i), busy, vt[i].busy);
            check($sformatf("vec%0d_hm_req", i), hm_req, vt[i].req);
            check($sformatf("vec%0d_irq", i), irq, vt[i].irq);
            check($sformatf("vec%0d_err", i), err, vt[i].err);
            tick();
        end
        hm_ack = 1'b0; irq_ack = 1'b0; hm_start = 1'b0; user_irq = 1'b0;
        model_hm_data = 64'hA5A5_0000_1234_5678;
        check("vec_req_addr", hm_req_addr, 64'h40);
        check("vec_hm_data", hm_data, model_hm_data);
        check("vec_irq_data", irq_data, 64'h77);

        en = 1'b1;
        tick();
        do_mload(64'h1000, 64'hDEAD_BEEF_CAFE_F00D, 5, 1'b1, 1'b0, 1'b0);
        do_int(64'h55, 10, 1'b1);
        do_mload(64'h2000, 64'h1111_2222_3333_4444, TB_TIMEOUT + 2, 1'b1, 1'b0, 1'b0);
        do_mload(64'h3000, 64'h0123_4567_89AB_CDEF, TB_TIMEOUT, 1'b1, 1'b0, 1'b0);
        do_mload(64'h4000, 64'hFEED_FACE_0000_0001, 3, 1'b1, 1'b0, 1'b1);
        do_mload(64'h5000, 64'h0BAD_F00D_0000_0002, 1, 1'b0, 1'b1, 1'b0);
        do_int(64'h66, 1, 1'b1);
        repeat (4) do_plain(1'b1);

        for (int t = 0; t < 60; t++) begin
            int kind, k;
            logic wi;
            kind = $urandom_range(0, 2);
            wi = 1'($urandom_range(0, 1));
            if (kind == 0) begin
                do_plain(wi);
            end else if (kind == 1) begin
                k = $urandom_range(1, TB_TIMEOUT + 3);
                do_mload({$urandom, $urandom}, {$urandom, $urandom}, k, wi,
                         1'($urandom_range(0, 3) == 0),
                         1'((k <= TB_TIMEOUT) && ($urandom_range(0, 5) == 0)));
            end else begin
                do_int({$urandom, $urandom}, $urandom_range(1, 6), wi);
            end
        end

        // Reset in IRQ_WAIT, then a stray ack after reset.
        user_irq = 1'b1;
        user_data = 64'h99;
        we_in = 1'b1;
        tick();
        tick();
        check("rst_seq_irq_high", irq, 1);
        @(negedge sys_clk);
        #1;
        sys_rst = 1'b1;
        irq_ack = 1'b1;
        #1;
        check("async_rst_irq", irq, 0);
        check("async_rst_ip_en", ip_en, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_irq_data", irq_data, 0);
        check("async_rst_req_addr", hm_req_addr, 0);
        tick();
        irq_ack = 1'b0;
        user_irq = 1'b0;
        sys_rst = 1'b0;
        hm_ack = 1'b1;
        hm_rdata = 64'hFFFF_0000_FFFF_0000;
        @(negedge sys_clk);
        check("post_rst_ip_en", ip_en, 0);
        tick();
        hm_ack = 1'b0;
        check("post_rst_late_ack", hm_data, 0);
        check("post_rst_hm_req", hm_req, 0);
        do_plain(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
